e1_rx_clk_rec: RTL and testbench
================================

# e1_rx_clk_rec

Receive-side clock and data recovery for the E1 line interface. Takes the raw, asynchronous positive/negative pulse comparator outputs from the line receiver and oversamples them at the fabric clock. It deglitches them, tracks bit phase with a bounded digital phase adjust, and emits one ternary symbol per recovered bit period. Its outputs drive the HDB3 decoder's `in_pos`/`in_neg`/`in_valid` directly. It also flags loss of signal.

## Interface

Parameters:
- `DIV`, 15 — nominal fabric clocks per E1 bit (30.72 MHz / 2.048 Mb/s); legal range 8..31.
- `SAMPLE_PH`, 3 — phase-counter value at which the symbol is sampled (mid-pulse of the RZ half-bit); must be < DIV/2.
- `LOS_BITS`, 32 — consecutive zero symbols that assert LOS; legal range 2..255.

Ports:
- `clk`  in  1  fabric clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low; all flops are cleared on assertion.
- `pad_pos`  in  1  raw positive-pulse comparator, asynchronous to `clk`.
- `pad_neg`  in  1  raw negative-pulse comparator, asynchronous to `clk`.
- `out_pos`  out  1  recovered symbol: positive pulse.
- `out_neg`  out  1  recovered symbol: negative pulse.
- `out_valid`  out  1  one-cycle strobe; `out_pos`/`out_neg` are meaningful only while it is high.
- `los`  out  1  loss of signal.

## Operation

- **Synchronizer:** each pad goes through a 2-flop synchronizer (`s0`→`s1`).
- **Deglitch:** a 3-deep shift history of `s1` per line.
  - `filt` is set to 1 when all three entries are 1, cleared when all three are 0, and holds otherwise.
  - Pulses or gaps shorter than 3 clocks are rejected.
- **Edge event:** `edge` is the rising edge of `(filt_pos | filt_neg)`, i.e. the start of a pulse of either polarity. Falling edges are ignored.
- **Phase counter:** `ph` counts 0..DIV-1 and wraps to 0.
  - No edge: `ph` advances by 1.
  - Edge with `ph == 0`: advance by 1 (in phase).
  - Edge with 1 ≤ `ph` ≤ (DIV-1)/2: `ph` holds one cycle (local clock early).
  - Edge with `ph` > (DIV-1)/2: `ph` advances by 2 with modulo-DIV wrap (local clock late).
  - Correction is therefore at most ±1 clock per pulse. Zeros carry no phase information and the counter free-runs through them.
- **Symbol sample:** on the cycle where `ph == SAMPLE_PH` and `ph` advances (not held):
  - `out_pos` ← `filt_pos`, `out_neg` ← `filt_neg`, `out_valid` ← 1 on the next edge.
  - Otherwise `out_valid` ← 0 and `out_pos`/`out_neg` hold.
  - A hold at `ph == SAMPLE_PH` delays the sample by one clock. It never duplicates or drops it.
  - The +2 step never skips `SAMPLE_PH`, because +2 steps occur only above (DIV-1)/2 and wrap at most to 1 (`SAMPLE_PH` ≥ 2 required; 3 by default).
- **Both lines high:** passed through unmodified as pos=1, neg=1. The downstream decoder treats this as zero/error.
- **LOS:** an 8-bit zero-run counter updated at each sample.
  - A sample with `filt_pos | filt_neg` clears it to 0 and deasserts `los`.
  - A zero sample increments it, saturating at 255.
  - `los` asserts on the sample where the count reaches `LOS_BITS`.
- **Reset values:** `ph` = 0, `filt_*` = 0, history and synchronizers = 0, `out_pos` = 0, `out_neg` = 0, `out_valid` = 0, zero-run = 0, `los` = 1.
  - Reset may assert at any time. Outputs go to reset values immediately (asynchronously).
  - Recovery is synchronous: the first `out_valid` comes SAMPLE_PH+1 clocks after the first clock edge with `rst_n` high.

## Timing

- Pad-to-`filt` latency: 5 clocks from the first clock edge sampling the new level (2 sync + 3 history, `filt` registered).
- `out_valid` spacing: DIV clocks in lock. DIV+1 after a hold; DIV-1 after a +2 step. It is never adjacent cycles.
- In lock, the pulse rising edge aligns with `ph == 0`. The sample lands SAMPLE_PH clocks into the (filtered) pulse, which is inside a nominal DIV/2-wide RZ pulse.
- Tracking range: ±1 clock per pulse. This covers ±1/DIV frequency error at full ones density and far exceeds the G.703 ±50 ppm.
- `los` changes only together with an `out_valid` strobe.

## Test plan

- **Reset:** hold `rst_n` = 0.
  - Required: `out_valid` = 0, `out_pos` = `out_neg` = 0, `los` = 1.
  - Release, no pad activity: `out_valid` pulses every 15 clocks with pos = neg = 0; `los` stays 1.
- **Locked all-ones:** drive alternating pos/neg pulses, 7 clocks wide, every 15 clocks, arbitrary initial phase.
  - Required: after at most 8 pulses, every `out_valid` strobe is 15 clocks apart with alternating `out_pos`/`out_neg`.
  - `los` drops on the first strobe that sees a pulse.
- **Glitch rejection:** in a zero bit, insert a 2-clock pulse on `pad_pos`.
  - Required: `filt_pos` never rises, the symbol is decoded as zero, and `ph` is undisturbed.
- **Frequency offset:** bit periods alternate 15,15,15,16 (slow) for 1000 bits, then 15,15,15,14 (fast) for 1000 bits, with mixed data at ≥ 50% ones.
  - Required: the output symbol stream equals the input stream with no slips, duplicates or drops.
- **LOS:** in lock, send 31 zeros then a pulse: `los` stays 0.
  - Then send 32 zeros: `los` asserts with the 32nd zero strobe.
  - The next pulse deasserts it on that pulse's strobe.
- **Async reset mid-stream:** pull `rst_n` low between strobes.
  - Required: outputs reset without waiting for a clock edge. After release, the block relocks within 8 pulses.

Source files
------------

// File: rtl/e1_rx_clk_rec.sv
// rtl/e1_rx_clk_rec.sv - E1 receive clock/data recovery: sync, deglitch, phase track, LOS
module e1_rx_clk_rec #(
   parameter int DIV       = 15,
   parameter int SAMPLE_PH = 3,
   parameter int LOS_BITS  = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pad_pos,
   input  logic pad_neg,
   output logic out_pos,
   output logic out_neg,
   output logic out_valid,
   output logic los
);

   localparam logic [5:0] LP_DIV  = 6'(DIV);
   localparam logic [4:0] LP_HALF = 5'((DIV - 1) / 2);
   localparam logic [4:0] LP_SPH  = 5'(SAMPLE_PH);
   localparam logic [7:0] LP_LOS  = 8'(LOS_BITS);

   logic       r_pos_s0, r_pos_s1, r_neg_s0, r_neg_s1;
   logic [2:0] r_pos_h, r_neg_h;
   logic       r_filt_pos, r_filt_neg, r_any_d;
   logic [4:0] r_ph;
   logic [7:0] r_zrun;
   logic       r_out_pos, r_out_neg, r_out_valid, r_los;

   logic       w_any, w_edge, w_hold, w_step2, w_sample;
   logic [5:0] w_ph_p1, w_ph_p2, w_ph_wrap;
   logic [4:0] w_ph_next;
   logic [7:0] w_zrun_inc;
   logic       w_filt_pos_next, w_filt_neg_next;

   assign w_any   = r_filt_pos | r_filt_neg;
   assign w_edge  = w_any & ~r_any_d;
   // Edge in the first half means our clock runs early: stall; later half means late: skip ahead
   assign w_hold  = w_edge && (r_ph != 5'd0) && (r_ph <= LP_HALF);
   assign w_step2 = w_edge && (r_ph > LP_HALF);

   assign w_ph_p1   = {1'b0, r_ph} + 6'd1;
   assign w_ph_p2   = {1'b0, r_ph} + 6'd2;
   assign w_ph_wrap = w_ph_p2 - LP_DIV;

   always_comb begin
      w_ph_next = r_ph;
      if (w_hold) begin
         w_ph_next = r_ph;
      end else if (w_step2) begin
         if (w_ph_p2 >= LP_DIV) w_ph_next = w_ph_wrap[4:0];
         else                   w_ph_next = w_ph_p2[4:0];
      end else begin
         if (w_ph_p1 >= LP_DIV) w_ph_next = 5'd0;
         else                   w_ph_next = w_ph_p1[4:0];
      end
   end

   assign w_sample   = (r_ph == LP_SPH) && !w_hold;
   assign w_zrun_inc = (r_zrun == 8'hFF) ? r_zrun : r_zrun + 8'd1;

   always_comb begin
      w_filt_pos_next = r_filt_pos;
      w_filt_neg_next = r_filt_neg;
      if (&r_pos_h)       w_filt_pos_next = 1'b1;
      else if (~|r_pos_h) w_filt_pos_next = 1'b0;
      if (&r_neg_h)       w_filt_neg_next = 1'b1;
      else if (~|r_neg_h) w_filt_neg_next = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos_s0    <= 1'b0;
         r_pos_s1    <= 1'b0;
         r_neg_s0    <= 1'b0;
         r_neg_s1    <= 1'b0;
         r_pos_h     <= 3'd0;
         r_neg_h     <= 3'd0;
         r_filt_pos  <= 1'b0;
         r_filt_neg  <= 1'b0;
         r_any_d     <= 1'b0;
         r_ph        <= 5'd0;
         r_zrun      <= 8'd0;
         r_out_pos   <= 1'b0;
         r_out_neg   <= 1'b0;
         r_out_valid <= 1'b0;
         r_los       <= 1'b1;
      end else begin
         r_pos_s0    <= pad_pos;
         r_pos_s1    <= r_pos_s0;
         r_neg_s0    <= pad_neg;
         r_neg_s1    <= r_neg_s0;
         r_pos_h     <= {r_pos_h[1:0], r_pos_s1};
         r_neg_h     <= {r_neg_h[1:0], r_neg_s1};
         r_filt_pos  <= w_filt_pos_next;
         r_filt_neg  <= w_filt_neg_next;
         r_any_d     <= w_any;
         r_ph        <= w_ph_next;
         r_out_valid <= w_sample;
         if (w_sample) begin
            r_out_pos <= r_filt_pos;
            r_out_neg <= r_filt_neg;
            if (w_any) begin
               r_zrun <= 8'd0;
               r_los  <= 1'b0;
            end else begin
               r_zrun <= w_zrun_inc;
               if (w_zrun_inc >= LP_LOS) r_los <= 1'b1;
            end
         end
      end
   end

   assign out_pos   = r_out_pos;
   assign out_neg   = r_out_neg;
   assign out_valid = r_out_valid;
   assign los       = r_los;

endmodule

// File: tb/tb_e1_rx_clk_rec.sv
// tb/tb_e1_rx_clk_rec.sv - self-checking bench for e1_rx_clk_rec
module tb_e1_rx_clk_rec;

   logic clk = 1'b0;
   logic rst_n, pad_pos, pad_neg;
   logic out_pos, out_neg, out_valid, los;

   always #5 clk = ~clk;

   e1_rx_clk_rec #(.DIV(15), .SAMPLE_PH(3), .LOS_BITS(32)) dut (
      .clk(clk), .rst_n(rst_n), .pad_pos(pad_pos), .pad_neg(pad_neg),
      .out_pos(out_pos), .out_neg(out_neg), .out_valid(out_valid), .los(los)
   );

   typedef struct { logic p; logic n; logic l; int cyc; } strobe_t;
   typedef struct { logic p; logic n; logic ep; logic en; logic el; } vec_t;

   strobe_t sq[$];
   vec_t    tbl[$];
   int      checks = 0;
   int      failures = 0;
   int      cyc = 0;
   logic    prev_v = 1'b0;
   logic    pol = 1'b1;
   logic    glitch_win = 1'b0;
   logic    filt_rose = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (glitch_win && dut.r_filt_pos) filt_rose = 1'b1;
   end

   always @(negedge clk) begin
      if (out_valid) begin
         strobe_t s;
         s.p = out_pos; s.n = out_neg; s.l = los; s.cyc = cyc;
         sq.push_back(s);
         chk("strobe_not_adjacent", int'(prev_v), 0);
      end
      prev_v = out_valid;
   end

   task automatic send_bit(input logic p, input logic n, input int period);
      pad_pos = p; pad_neg = n;
      repeat (7) @(negedge clk);
      pad_pos = 1'b0; pad_neg = 1'b0;
      repeat (period - 7) @(negedge clk);
   endtask

   task automatic send_ones_check(input int nacq, input int nchk, input string name);
      logic ep[$];
      int m, got;
      for (int i = 0; i < nacq; i++) begin
         send_bit(pol, !pol, 15);
         pol = !pol;
      end
      m = sq.size();
      for (int i = 0; i < nchk; i++) begin
         ep.push_back(pol);
         send_bit(pol, !pol, 15);
         pol = !pol;
      end
      got = sq.size() - m;
      chk($sformatf("%s.count", name), got, nchk);
      for (int i = 0; i < nchk && i < got; i++) begin
         chk($sformatf("%s[%0d].sym", name, i), {sq[m+i].p, sq[m+i].n}, {ep[i], !ep[i]});
         if (i > 0) chk($sformatf("%s[%0d].gap", name, i), sq[m+i].cyc - sq[m+i-1].cyc, 15);
      end
   endtask

   task automatic add_vec(input logic p, input logic n, input logic ep, input logic en, input logic el);
      vec_t v;
      v.p = p; v.n = n; v.ep = ep; v.en = en; v.el = el;
      tbl.push_back(v);
   endtask

   initial begin
      int c0, m, got, k;
      logic fp[$];
      logic fn[$];
      logic one;
      int per;

      rst_n = 1'b0; pad_pos = 1'b0; pad_neg = 1'b0;

      add_vec(1, 0, 1, 0, 0);
      add_vec(0, 1, 0, 1, 0);
      add_vec(0, 0, 0, 0, 0);
      add_vec(1, 1, 1, 1, 0);
      add_vec(0, 1, 0, 1, 0);
      for (int i = 0; i < 31; i++) add_vec(0, 0, 0, 0, 0);
      add_vec(1, 0, 1, 0, 0);
      for (int i = 0; i < 32; i++) add_vec(0, 0, 0, 0, (i == 31));
      add_vec(0, 1, 0, 1, 0);
      add_vec(0, 0, 0, 0, 0);

      // Reset state and free-running strobes with no line activity
      repeat (3) @(negedge clk);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.out_pos", out_pos, 0);
      chk("rst.out_neg", out_neg, 0);
      chk("rst.los", los, 1);
      c0 = cyc;
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      chk("rst.nstrobes_ge3", int'(sq.size() >= 3), 1);
      if (sq.size() >= 3) begin
         chk("rst.first_strobe_cyc", sq[0].cyc - c0, 4);
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst.s%0d.sym", i), {sq[i].p, sq[i].n}, 0);
            chk($sformatf("rst.s%0d.los", i), sq[i].l, 1);
            if (i > 0) chk($sformatf("rst.s%0d.gap", i), sq[i].cyc - sq[i-1].cyc, 15);
         end
      end

      // Lock from arbitrary phase, then LOS must have dropped on the first pulse strobe
      repeat ($urandom_range(0, 14)) @(negedge clk);
      m = sq.size();
      send_ones_check(8, 12, "lock");
      k = -1;
      for (int i = m; i < sq.size(); i++)
         if (k < 0 && (sq[i].p | sq[i].n)) k = i;
      chk("lock.found_pulse", int'(k > 0), 1);
      if (k > 0) begin
         chk("lock.los_at_first_pulse", sq[k].l, 0);
         chk("lock.los_before_pulse", sq[k-1].l, 1);
      end

      // Vector table at nominal rate: symbols, both-high, LOS run lengths
      m = sq.size();
      foreach (tbl[i]) send_bit(tbl[i].p, tbl[i].n, 15);
      got = sq.size() - m;
      chk("tbl.count", got, tbl.size());
      for (int i = 0; i < tbl.size() && i < got; i++) begin
         chk($sformatf("tbl[%0d].pos", i), sq[m+i].p, tbl[i].ep);
         chk($sformatf("tbl[%0d].neg", i), sq[m+i].n, tbl[i].en);
         chk($sformatf("tbl[%0d].los", i), sq[m+i].l, tbl[i].el);
      end

      // 2-clock glitch inside a zero bit
      m = sq.size();
      filt_rose = 1'b0;
      glitch_win = 1'b1;
      send_bit(0, 1, 15);
      repeat (5) @(negedge clk);
      pad_pos = 1'b1;
      repeat (2) @(negedge clk);
      pad_pos = 1'b0;
      repeat (8) @(negedge clk);
      send_bit(0, 1, 15);
      glitch_win = 1'b0;
      chk("glitch.filt_pos_rose", filt_rose, 0);
      got = sq.size() - m;
      chk("glitch.count", got, 3);
      if (got == 3) begin
         chk("glitch.s0", {sq[m].p, sq[m].n}, 2'b01);
         chk("glitch.s1_zero", {sq[m+1].p, sq[m+1].n}, 2'b00);
         chk("glitch.s2", {sq[m+2].p, sq[m+2].n}, 2'b01);
         chk("glitch.gap1", sq[m+1].cyc - sq[m].cyc, 15);
         chk("glitch.gap2", sq[m+2].cyc - sq[m+1].cyc, 15);
      end

      // Frequency offset: slow then fast periods with mixed AMI data
      m = sq.size();
      for (int i = 0; i < 2000; i++) begin
         one = ($urandom_range(0, 3) != 0);
         per = (i % 4 == 3) ? ((i < 1000) ? 16 : 14) : 15;
         if (one) begin
            fp.push_back(pol); fn.push_back(!pol);
            send_bit(pol, !pol, per);
            pol = !pol;
         end else begin
            fp.push_back(1'b0); fn.push_back(1'b0);
            send_bit(0, 0, per);
         end
      end
      got = sq.size() - m;
      chk("freq.count", got, 2000);
      for (int i = 0; i < 2000 && i < got; i++)
         chk($sformatf("freq[%0d].sym", i), {sq[m+i].p, sq[m+i].n}, {fp[i], fn[i]});

      // Asynchronous reset between strobes, then relock
      pol = 1'b1;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               send_bit(pol, !pol, 15);
               pol = !pol;
            end
         end
         begin
            int n;
            n = 0;
            while (n < 100 && !(out_valid && out_pos)) begin
               @(negedge clk);
               n++;
            end
            chk("arst.saw_pos_strobe", int'(n < 100), 1);
            @(posedge clk);
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("arst.out_valid", out_valid, 0);
            chk("arst.out_pos", out_pos, 0);
            chk("arst.out_neg", out_neg, 0);
            chk("arst.los", los, 1);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      send_ones_check(8, 8, "relock");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
